// File: rtl/grover_pkg.sv
// grover_pkg -- shared definitions for the Grover diffusion block.
//   AMP_W  : amplitude width (signed two's complement)
//   N_AMP  : number of amplitudes in a vector
//   ACC_W  : signed accumulator width for the amplitude sum
//   REF_W  : signed width of the reflection 2*mean - a_k
//   state_e: FSM encoding (IDLE, SUM, MEAN, REFLECT, DONE)
package grover_pkg;

  localparam int AMP_W = 8;
  localparam int N_AMP = 8;
  localparam int ACC_W = 11;
  localparam int REF_W = 10;
  localparam int IDX_W = 3;

  localparam logic [IDX_W-1:0] LAST_IDX = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SUM     = 3'd1,
    ST_MEAN    = 3'd2,
    ST_REFLECT = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/grover_reflect_unit.sv
// grover_reflect_unit -- combinational inversion about the mean for one amplitude.
//   mean : signed mean of the vector (AMP_W bits)
//   a    : signed amplitude a_k (AMP_W bits)
//   r    : signed result r_k = 2*mean - a_k reduced to AMP_W bits
// Build option: GROVER_DIFFUSION_SAT_EN defined -> r saturates to [-128, 127];
// undefined -> r is the low AMP_W bits of the exact result (two's-complement wrap).
module grover_reflect_unit #(
  parameter int AMP_W = 8
) (
  input  logic signed [AMP_W-1:0] mean,
  input  logic signed [AMP_W-1:0] a,
  output logic signed [AMP_W-1:0] r
);
  import grover_pkg::*;

  localparam logic signed [REF_W-1:0] SAT_MAX = 10'sd127;
  localparam logic signed [REF_W-1:0] SAT_MIN = -10'sd128;

  logic signed [REF_W-1:0] mean_ext_s;
  logic signed [REF_W-1:0] a_ext_s;
  logic signed [REF_W-1:0] r_full_s;

  // Exact reflection in REF_W bits: |2*mean - a| never exceeds 383, so no overflow here.
  always_comb begin
    mean_ext_s = {{(REF_W-AMP_W){mean[AMP_W-1]}}, mean};
    a_ext_s    = {{(REF_W-AMP_W){a[AMP_W-1]}}, a};
    r_full_s   = (mean_ext_s <<< 1) - a_ext_s;
  end

`ifdef GROVER_DIFFUSION_SAT_EN
  // Clamp the exact result into the amplitude range.
  always_comb begin
    if (r_full_s > SAT_MAX) begin
      r = 8'sh7F;
    end else if (r_full_s < SAT_MIN) begin
      r = 8'sh80;
    end else begin
      r = r_full_s[AMP_W-1:0];
    end
  end
`else
  // Keep only the low bits of the exact result.
  always_comb begin
    r = r_full_s[AMP_W-1:0];
  end
`endif

endmodule

// File: rtl/grover_diffusion.sv
// grover_diffusion -- Grover diffusion (inversion about the mean) over 8 amplitudes.
//   clk, rst_n : single clock, asynchronous active-low reset
//   in_valid   : upstream vector i0..i7 valid; accepted only while in_ready
//   in_ready   : high only in IDLE
//   i0..i7     : signed input amplitudes (after phase inversion of the target)
//   out_valid  : o0..o7 hold a finished result; held until out_ready
//   out_ready  : downstream accepts the result
//   o0..o7     : registered signed amplitudes 2*mean - a_k
//   busy       : high in every state except IDLE
// Build option: GROVER_DIFFUSION_SAT_EN selects saturation of r_k (see
// grover_reflect_unit); undefined wraps r_k to AMP_W bits.
// Timing: accept edge, 8 SUM edges, 1 MEAN edge, 8 REFLECT edges, then out_valid
// rises on the first DONE edge, 18 edges after acceptance.
module grover_diffusion #(
  parameter int AMP_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [AMP_W-1:0] i0,
  input  logic signed [AMP_W-1:0] i1,
  input  logic signed [AMP_W-1:0] i2,
  input  logic signed [AMP_W-1:0] i3,
  input  logic signed [AMP_W-1:0] i4,
  input  logic signed [AMP_W-1:0] i5,
  input  logic signed [AMP_W-1:0] i6,
  input  logic signed [AMP_W-1:0] i7,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [AMP_W-1:0] o0,
  output logic signed [AMP_W-1:0] o1,
  output logic signed [AMP_W-1:0] o2,
  output logic signed [AMP_W-1:0] o3,
  output logic signed [AMP_W-1:0] o4,
  output logic signed [AMP_W-1:0] o5,
  output logic signed [AMP_W-1:0] o6,
  output logic signed [AMP_W-1:0] o7,
  output logic                    busy
);
  import grover_pkg::*;

  state_e                  state_r;
  logic [IDX_W-1:0]        idx_r;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [AMP_W-1:0] mean_r;
  logic signed [AMP_W-1:0] amp_r [N_AMP];
  logic signed [AMP_W-1:0] o_r [N_AMP];
  logic                    out_valid_r;

  logic signed [AMP_W-1:0] in_vec_s [N_AMP];
  logic signed [AMP_W-1:0] cur_amp_s;
  logic signed [ACC_W-1:0] cur_ext_s;
  logic signed [AMP_W-1:0] refl_s;
  logic                    last_idx_s;

  assign in_vec_s = '{i0, i1, i2, i3, i4, i5, i6, i7};

  // Select the amplitude addressed by the shared index and sign-extend it for the sum.
  always_comb begin
    cur_amp_s  = amp_r[idx_r];
    cur_ext_s  = {{(ACC_W-AMP_W){cur_amp_s[AMP_W-1]}}, cur_amp_s};
    last_idx_s = (idx_r == LAST_IDX);
  end

  grover_reflect_unit #(
    .AMP_W (AMP_W)
  ) u_reflect (
    .mean (mean_r),
    .a    (cur_amp_s),
    .r    (refl_s)
  );

  // Main sequencer: capture, serial sum, mean, serial reflect, output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= '0;
      acc_r       <= '0;
      mean_r      <= '0;
      out_valid_r <= 1'b0;
      for (int k = 0; k < N_AMP; k++) begin
        amp_r[k] <= '0;
        o_r[k]   <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            amp_r   <= in_vec_s;
            acc_r   <= '0;
            idx_r   <= '0;
            state_r <= ST_SUM;
          end
        end
        ST_SUM: begin
          acc_r <= acc_r + cur_ext_s;
          idx_r <= idx_r + 3'd1;  // wraps 7 -> 0 on the way to MEAN
          if (last_idx_s) begin
            state_r <= ST_MEAN;
          end
        end
        ST_MEAN: begin
          // Dropping the low 3 bits of the signed sum is an arithmetic shift (floor).
          mean_r  <= acc_r[ACC_W-1:3];
          state_r <= ST_REFLECT;
        end
        ST_REFLECT: begin
          o_r[idx_r] <= refl_s;
          idx_r      <= idx_r + 3'd1;  // wraps 7 -> 0 on the way to DONE
          if (last_idx_s) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          // First DONE edge raises out_valid; afterwards wait for out_ready.
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign out_valid = out_valid_r;
  assign o0 = o_r[0];
  assign o1 = o_r[1];
  assign o2 = o_r[2];
  assign o3 = o_r[3];
  assign o4 = o_r[4];
  assign o5 = o_r[5];
  assign o6 = o_r[6];
  assign o7 = o_r[7];

endmodule

// File: tb/tb_grover_diffusion.sv
// tb_grover_diffusion -- directed self-checking bench for grover_diffusion.
// Expected result vectors go into a scoreboard queue when a vector is accepted
// and are popped when out_valid is seen. Vectors are packed {x7,...,x0}.
module tb_grover_diffusion;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic busy;
  logic signed [7:0] i_v [8];
  logic signed [7:0] o0, o1, o2, o3, o4, o5, o6, o7;
  logic [63:0] o_all;

  logic [63:0] sb [$];
  int n_tests = 0;
  int n_fail  = 0;

  assign o_all = {o7, o6, o5, o4, o3, o2, o1, o0};

  grover_diffusion #(.AMP_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i0 (i_v[0]), .i1 (i_v[1]), .i2 (i_v[2]), .i3 (i_v[3]),
    .i4 (i_v[4]), .i5 (i_v[5]), .i6 (i_v[6]), .i7 (i_v[7]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o0 (o0), .o1 (o1), .o2 (o2), .o3 (o3),
    .o4 (o4), .o5 (o5), .o6 (o6), .o7 (o7),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: floor mean of the sum, then 2*mean - a_k, saturated or wrapped.
  function automatic logic [63:0] model(input logic [63:0] v);
    int sum;
    int mean;
    int r;
    logic [63:0] res;
    sum = 0;
    for (int k = 0; k < 8; k++) sum += int'($signed(v[8*k +: 8]));
    mean = sum >>> 3;
    res = '0;
    for (int k = 0; k < 8; k++) begin
      r = 2 * mean - int'($signed(v[8*k +: 8]));
`ifdef GROVER_DIFFUSION_SAT_EN
      if (r > 127) r = 127;
      if (r < -128) r = -128;
`endif
      res[8*k +: 8] = r[7:0];
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic drive_vec(input logic [63:0] v);
    for (int k = 0; k < 8; k++) i_v[k] = v[8*k +: 8];
  endtask

  // Present v from IDLE, push its expectation, wait for out_valid and compare.
  task automatic do_vec(input string tag, input logic [63:0] v, input logic [63:0] e);
    int lat;
    logic [63:0] got;
    drive_vec(v);
    in_valid = 1'b1;
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drive_vec(64'h5A5A_5A5A_5A5A_5A5A);
    sb.push_back(e);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd18);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk({tag, " data"}, o_all, got);
    end
  endtask

  // Complete the output handshake and check the return to IDLE with outputs retained.
  task automatic handoff(input string tag, input logic [63:0] e);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
    chk({tag, " idle"}, 64'({in_ready, busy}), 64'b10);
    chk({tag, " retained"}, o_all, e);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] v;
    logic [63:0] e;
    logic [63:0] got;
    int accepts;
    int outs;
    int last_acc;
    int ov_seen;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive_vec(64'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", o_all, 64'h0);
    chk("reset flags", 64'({out_valid, busy}), 64'b00);
    rst_n = 1'b1;
    #1;
    chk("reset in_ready", 64'(in_ready), 64'd1);

    // Mixed signs: sum 28, mean 3.
    v = {8'd8, 8'd7, 8'd6, 8'd5, 8'hFC, 8'd3, 8'd2, 8'd1};
    e = {8'hFE, 8'hFF, 8'h00, 8'h01, 8'h0A, 8'h03, 8'h04, 8'h05};
    do_vec("v27", v, e);
    chk("v27 model", model(v), e);
    handoff("v27", e);

    // Single negated target: mean 12, o3 = 40.
    v = {8'd16, 8'd16, 8'd16, 8'd16, 8'hF0, 8'd16, 8'd16, 8'd16};
    e = {8'd8, 8'd8, 8'd8, 8'd8, 8'd40, 8'd8, 8'd8, 8'd8};
    do_vec("v28", v, e);
    handoff("v28", e);

    // Overflow corner: r0 = 318 before reduction.
`ifdef GROVER_DIFFUSION_SAT_EN
    e = {8'd63, 8'd63, 8'd63, 8'd63, 8'd63, 8'd63, 8'd63, 8'd127};
`else
    e = {8'd63, 8'd63, 8'd63, 8'd63, 8'd63, 8'd63, 8'd63, 8'd62};
`endif
    v = {8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'h80};
    do_vec("v29", v, e);
    handoff("v29", e);

    // Negative sum -9: floor mean is -2, not -1.
    v = {8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    e = {8'hFE, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD};
    do_vec("vneg", v, e);
    handoff("vneg", e);

    // Back-pressure: hold out_ready low for 5 cycles; in_valid meanwhile is ignored.
    v = {$urandom, $urandom};
    e = model(v);
    do_vec("bp", v, e);
    drive_vec(64'h1122_3344_5566_7788);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp hold data", o_all, e);
      chk("bp hold flags", 64'({out_valid, in_ready, busy}), 64'b101);
    end
    in_valid = 1'b0;
    handoff("bp", e);

    // Two more random vectors.
    for (int n = 0; n < 2; n++) begin
      v = {$urandom, $urandom};
      e = model(v);
      do_vec("rand", v, e);
      handoff("rand", e);
    end

    // Reset during REFLECT index 4 aborts the operation.
    v = {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    drive_vec(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(model(v));
    repeat (13) @(posedge clk);
    #1;
    chk("abort pre busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("abort outputs", o_all, 64'h0);
    chk("abort flags", 64'({out_valid, busy}), 64'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("abort in_ready", 64'(in_ready), 64'd1);
    ov_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) ov_seen++;
    end
    chk("abort no out_valid", 64'(ov_seen), 64'd0);
    v = {8'hF6, 8'd3, 8'h81, 8'd100, 8'd0, 8'hC0, 8'd7, 8'd45};
    e = model(v);
    do_vec("post abort", v, e);
    handoff("post abort", e);

    // Streaming: in_valid and out_ready tied high, one vector per 20 cycles.
    v = {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'hF9};
    drive_vec(v);
    e = model(v);
    out_ready = 1'b1;
    in_valid = 1'b1;
    accepts = 0;
    outs = 0;
    last_acc = -1;
    for (int c = 0; c < 100; c++) begin
      if (out_valid === 1'b1) begin
        outs++;
        if (sb.size() > 0) begin
          got = sb.pop_front();
          chk("stream data", o_all, got);
        end
      end
      if (in_ready === 1'b1) begin
        if (last_acc >= 0) chk("stream spacing", 64'(c - last_acc), 64'd20);
        last_acc = c;
        accepts++;
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("stream accepts", 64'(accepts), 64'd5);
    chk("stream outputs", 64'(outs), 64'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
